// File: rtl/db_mv_ram_sp_arb.sv
// rtl/db_mv_ram_sp_arb.sv - single-port MV buffer shared by MV writer and BS reader
// Write-priority arbitration with a starvation guard for the reader, plus a self-timed zero sweep.
module db_mv_ram_sp_arb #(
    parameter int DATA_W     = 20,
    parameter int ADDR_W     = 9,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    output logic              busy_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_adr_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    output logic              wr_ack_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_adr_i,
    output logic              rd_ack_o,
    output logic              rd_val_o,
    output logic [DATA_W-1:0] rd_dat_o
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [3:0]        starve_q, starve_d;

    logic              arb_en;
    logic              rd_win;
    logic              wr_ack;
    logic              rd_ack;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              rd1_v_q;
    logic [DATA_W-1:0] rd1_d_q;

    // The reader only wins a conflict once it has been denied STARVE_MAX times in a row.
    always_comb begin
        arb_en = (state_q == ST_IDLE) && !clr_i;
        rd_win = rd_req_i && (!wr_req_i || (starve_q == STARVE_LIM));
        rd_ack = arb_en && rd_win;
        wr_ack = arb_en && wr_req_i && !rd_win;
    end

    assign wr_ack_o = wr_ack;
    assign rd_ack_o = rd_ack;
    assign busy_o   = (state_q == ST_CLEAR);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!rd_req_i || rd_ack) begin
            starve_d = '0;
        end else if (wr_ack) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            starve_q  <= starve_d;
        end
    end

    // The sweep owns the write port; no ack can be granted while it runs.
    always_comb begin
        mem_we = wr_ack || (state_q == ST_CLEAR);
        mem_wa = (state_q == ST_CLEAR) ? clr_cnt_q : wr_adr_i;
        mem_wd = (state_q == ST_CLEAR) ? '0 : wr_dat_i;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_v_q <= 1'b0;
            rd1_d_q <= '0;
        end else begin
            rd1_v_q <= rd_ack;
            if (rd_ack) begin
                rd1_d_q <= mem[rd_adr_i];
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              rd2_v_q;
            logic [DATA_W-1:0] rd2_d_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd2_v_q <= 1'b0;
                    rd2_d_q <= '0;
                end else begin
                    rd2_v_q <= rd1_v_q;
                    if (rd1_v_q) begin
                        rd2_d_q <= rd1_d_q;
                    end
                end
            end

            assign rd_val_o = rd2_v_q;
            assign rd_dat_o = rd2_d_q;
        end else begin : g_lat1
            assign rd_val_o = rd1_v_q;
            assign rd_dat_o = rd1_d_q;
        end
    endgenerate

endmodule

// File: tb/tb_db_mv_ram_sp_arb.sv
// tb/tb_db_mv_ram_sp_arb.sv - self-checking bench for db_mv_ram_sp_arb
module tb_db_mv_ram_sp_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr, busy, wr_req, wr_ack, rd_req, rd_ack, rd_val;
    logic [8:0]  wr_adr, rd_adr;
    logic [19:0] wr_dat, rd_dat;

    logic        clr2, busy2, wr_req2, wr_ack2, rd_req2, rd_ack2, rd_val2;
    logic [8:0]  wr_adr2, rd_adr2;
    logic [19:0] wr_dat2, rd_dat2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [19:0] dat;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [19:0] model [512];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    db_mv_ram_sp_arb #(.DATA_W(20), .ADDR_W(9), .RD_LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .clr_i(clr), .busy_o(busy),
        .wr_req_i(wr_req), .wr_adr_i(wr_adr), .wr_dat_i(wr_dat), .wr_ack_o(wr_ack),
        .rd_req_i(rd_req), .rd_adr_i(rd_adr), .rd_ack_o(rd_ack),
        .rd_val_o(rd_val), .rd_dat_o(rd_dat)
    );

    db_mv_ram_sp_arb #(.DATA_W(20), .ADDR_W(9), .RD_LAT(2), .STARVE_MAX(4)) dut2 (
        .clk(clk), .rst(rst), .clr_i(clr2), .busy_o(busy2),
        .wr_req_i(wr_req2), .wr_adr_i(wr_adr2), .wr_dat_i(wr_dat2), .wr_ack_o(wr_ack2),
        .rd_req_i(rd_req2), .rd_adr_i(rd_adr2), .rd_ack_o(rd_ack2),
        .rd_val_o(rd_val2), .rd_dat_o(rd_dat2)
    );

    // Scoreboard monitor for the RD_LAT=1 instance: reads push, valid data pops.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (rd_val) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: rd_dat_o=%h with nothing outstanding", rd_dat);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (rd_dat !== e.dat || cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL sb_read: got data %h at cycle %0d, expected %h at cycle %0d",
                                 rd_dat, cyc, e.dat, e.cyc);
                    end
                end
            end
            if (rd_ack) sb_q.push_back('{model[rd_adr], cyc + 1});
            if (wr_ack) model[wr_adr] = wr_dat;
        end
    end

    task automatic do_write(input logic [8:0] a, input logic [19:0] d);
        int n = 0;
        wr_adr = a; wr_dat = d; wr_req = 1'b1;
        @(negedge clk);
        while (!wr_ack && n < 1000) begin @(negedge clk); n++; end
        if (!wr_ack) begin
            errors++;
            $display("FAIL wr_timeout: addr %h got no ack, required ack", a);
        end
        @(posedge clk); #1;
        wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [8:0] a);
        int n = 0;
        rd_adr = a; rd_req = 1'b1;
        @(negedge clk);
        while (!rd_ack && n < 1000) begin @(negedge clk); n++; end
        if (!rd_ack) begin
            errors++;
            $display("FAIL rd_timeout: addr %h got no ack, required ack", a);
        end
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads outstanding, required 0", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_val !== 1'b0 || rd_dat !== 20'h0) begin
            errors++;
            $display("FAIL reset_out: busy=%b val=%b dat=%h, required 0/0/0", busy, rd_val, rd_dat);
        end
        checks++;
        if (busy2 !== 1'b0 || rd_val2 !== 1'b0 || rd_dat2 !== 20'h0) begin
            errors++;
            $display("FAIL reset_out2: busy=%b val=%b dat=%h, required 0/0/0", busy2, rd_val2, rd_dat2);
        end
        checks++;
        if (wr_ack !== 1'b0 || rd_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_acks: wr=%b rd=%b, required 0/0", wr_ack, rd_ack);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        do_write(9'd5, 20'hABCDE);
        do_read(9'd5);
        wait_drain();
        wr_req2 = 1'b1; wr_adr2 = 9'd5; wr_dat2 = 20'hABCDE;
        @(negedge clk);
        checks++;
        if (wr_ack2 !== 1'b1) begin
            errors++;
            $display("FAIL lat2_wr_ack: got %b, required 1", wr_ack2);
        end
        @(posedge clk); #1;
        wr_req2 = 1'b0; rd_req2 = 1'b1; rd_adr2 = 9'd5;
        @(negedge clk);
        checks++;
        if (rd_ack2 !== 1'b1) begin
            errors++;
            $display("FAIL lat2_rd_ack: got %b, required 1", rd_ack2);
        end
        @(posedge clk); #1;
        rd_req2 = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_val2 !== 1'b0) begin
            errors++;
            $display("FAIL lat2_early: rd_val_o=%b one cycle after ack, required 0", rd_val2);
        end
        @(negedge clk);
        checks++;
        if (rd_val2 !== 1'b1 || rd_dat2 !== 20'hABCDE) begin
            errors++;
            $display("FAIL lat2_data: val=%b dat=%h, required 1/abcde", rd_val2, rd_dat2);
        end
        @(negedge clk);
        checks++;
        if (rd_val2 !== 1'b0 || rd_dat2 !== 20'hABCDE) begin
            errors++;
            $display("FAIL lat2_hold: val=%b dat=%h, required 0/abcde", rd_val2, rd_dat2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_inflight_clear();
        int n = 0;
        wr_req2 = 1'b1; wr_adr2 = 9'd7; wr_dat2 = 20'h12345;
        @(posedge clk); #1;
        wr_req2 = 1'b0; rd_req2 = 1'b1; rd_adr2 = 9'd7;
        @(negedge clk);
        checks++;
        if (rd_ack2 !== 1'b1) begin
            errors++;
            $display("FAIL inflight_ack: got %b, required 1", rd_ack2);
        end
        @(posedge clk); #1;
        rd_req2 = 1'b0; clr2 = 1'b1;
        @(posedge clk); #1;
        clr2 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy2 !== 1'b1 || rd_val2 !== 1'b1 || rd_dat2 !== 20'h12345) begin
            errors++;
            $display("FAIL inflight_data: busy=%b val=%b dat=%h, required 1/1/12345",
                     busy2, rd_val2, rd_dat2);
        end
        while (busy2 && n < 600) begin @(negedge clk); n++; end
        checks++;
        if (busy2 !== 1'b0) begin
            errors++;
            $display("FAIL inflight_busy_end: busy=%b, required 0", busy2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_conflict();
        logic exp_r;
        wr_req = 1'b1; wr_adr = 9'd10; wr_dat = 20'h55555;
        rd_req = 1'b1; rd_adr = 9'd5;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            exp_r = (i % 5 == 4);
            checks++;
            if (rd_ack !== exp_r || wr_ack !== !exp_r) begin
                errors++;
                $display("FAIL conflict_seq[%0d]: wr=%b rd=%b, required wr=%b rd=%b",
                         i, wr_ack, rd_ack, !exp_r, exp_r);
            end
            @(posedge clk); #1;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        wait_drain();
    endtask

    task automatic test_clear_sweep();
        int  n = 0;
        int  busy_cnt = 0;
        logic ack_seen = 1'b0;
        for (int a = 0; a < 512; a++) do_write(9'(a), 20'(a + 1));
        clr = 1'b1;
        wr_req = 1'b1; wr_adr = 9'd20; wr_dat = 20'h00777;
        rd_req = 1'b1; rd_adr = 9'd3;
        @(negedge clk);
        checks++;
        if (wr_ack !== 1'b0 || rd_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_start: wr=%b rd=%b busy=%b, required 0/0/0", wr_ack, rd_ack, busy);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        for (int a = 0; a < 512; a++) model[a] = 20'h0;
        @(negedge clk);
        while (busy && n < 600) begin
            if (wr_ack || rd_ack) ack_seen = 1'b1;
            busy_cnt++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (busy_cnt != 512) begin
            errors++;
            $display("FAIL clr_busy_len: busy for %0d cycles, required 512", busy_cnt);
        end
        checks++;
        if (ack_seen) begin
            errors++;
            $display("FAIL clr_no_ack: ack seen=%b during sweep, required 0", ack_seen);
        end
        checks++;
        if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin
            errors++;
            $display("FAIL clr_first_ack: wr=%b rd=%b after sweep, required 1/0", wr_ack, rd_ack);
        end
        @(posedge clk); #1;
        wr_req = 1'b0; rd_req = 1'b0;
        do_read(9'd0);
        do_read(9'd255);
        do_read(9'd511);
        wait_drain();
    endtask

    task automatic test_reset_mid_clear();
        for (int a = 0; a < 256; a++) do_write(9'(a), 20'(a + 1));
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (99) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rmc_busy_before: busy=%b, required 1", busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int a = 0; a < 100; a++) model[a] = 20'h0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_val !== 1'b0) begin
            errors++;
            $display("FAIL rmc_after: busy=%b val=%b, required 0/0", busy, rd_val);
        end
        @(posedge clk); #1;
        do_read(9'd50);
        do_read(9'd200);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        do_write(9'd0, 20'h0A0A0);
        do_write(9'd1, 20'h0B0B0);
        do_write(9'd2, 20'h0C0C0);
        rd_req = 1'b1; rd_adr = 9'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rd_ack !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ack[%0d]: got %b, required 1", k, rd_ack);
            end
            @(posedge clk); #1;
            rd_adr = 9'(k + 1);
        end
        rd_req = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);
        checks++;
        if (rd_val !== 1'b0 || rd_dat !== 20'h0C0C0) begin
            errors++;
            $display("FAIL b2b_hold: val=%b dat=%h, required 0/0c0c0", rd_val, rd_dat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_adr = '0; wr_dat = '0; rd_adr = '0;
        clr2 = 1'b0; wr_req2 = 1'b0; rd_req2 = 1'b0;
        wr_adr2 = '0; wr_dat2 = '0; rd_adr2 = '0;
        for (int a = 0; a < 512; a++) model[a] = 20'h0;
        test_reset();
        test_basic();
        test_inflight_clear();
        test_conflict();
        test_clear_sweep();
        test_reset_mid_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
